// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide (shift-add multiply, restoring divide).
// Define MULDIV_EARLY_OUT_EN to finish div-by-zero, signed overflow and multiply-by-zero in one cycle.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [2:0]       op_i,
   input  logic [XLEN-1:0]  operand1_i,
   input  logic [XLEN-1:0]  operand2_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic             flush_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [XLEN-1:0]  result_o,
   output logic [TAG_W-1:0] tag_o,
   output logic             zero_o
);
   localparam int CW = $clog2(XLEN);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t            state, state_nx;
   logic [CW-1:0]     cnt;
   logic [XLEN-1:0]   hi, lo, dv, op1_q, hi_nx, lo_nx, m1, m2, quo, rem;
   logic [2:0]        op_q;
   logic [TAG_W-1:0]  tag_q;
   logic              neg_q, neg_r, dz, s1, s2, n1, n2, ovf, accept, early;
   logic [XLEN:0]     sum, shf, dif;
   logic [2*XLEN-1:0] prod;
   always_comb begin
      s1     = ~op_i[0] | (op_i == 3'b001);
      s2     = s1 & (op_i != 3'b010);
      n1     = s1 & operand1_i[XLEN-1];
      n2     = s2 & operand2_i[XLEN-1];
      m1     = n1 ? -operand1_i : operand1_i;
      m2     = n2 ? -operand2_i : operand2_i;
      ovf    = op_i[2] & s1 & (operand1_i == {1'b1, {(XLEN-1){1'b0}}}) & (operand2_i == '1);
      accept = valid_i & ready_o & ~flush_i;
`ifdef MULDIV_EARLY_OUT_EN
      early  = (operand2_i == '0) | ovf;
`else
      early  = 1'b0;
`endif
   end
   // hi:lo is the product accumulator for multiply and remainder:quotient for divide
   always_comb begin
      sum   = {1'b0, hi} + (lo[0] ? {1'b0, dv} : '0);
      shf   = {hi, lo[XLEN-1]};
      dif   = shf - {1'b0, dv};
      hi_nx = op_q[2] ? (dif[XLEN] ? shf[XLEN-1:0] : dif[XLEN-1:0]) : sum[XLEN:1];
      lo_nx = op_q[2] ? {lo[XLEN-2:0], ~dif[XLEN]} : {sum[0], lo[XLEN-1:1]};
      prod  = neg_q ? -{hi, lo} : {hi, lo};
      quo   = dz ? '1 : (neg_q ? -lo : lo);
      rem   = dz ? op1_q : (neg_r ? -hi : hi);
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = accept ? (early ? DONE : CALC) : IDLE;
         CALC:    state_nx = (cnt == CW'(XLEN-1)) ? DONE : CALC;
         DONE:    state_nx = ready_i ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
      if (flush_i) state_nx = IDLE;
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         dv    <= '0;
         op1_q <= '0;
         op_q  <= '0;
         tag_q <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dz    <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            cnt   <= '0;
            hi    <= '0;
            lo    <= early ? (ovf ? operand1_i : '0) : m1;
            dv    <= m2;
            op1_q <= operand1_i;
            op_q  <= op_i;
            tag_q <= tag_i;
            neg_q <= n1 ^ n2;
            neg_r <= n1;
            dz    <= op_i[2] & (operand2_i == '0);
         end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            hi  <= hi_nx;
            lo  <= lo_nx;
         end
      end
   end
   assign ready_o  = state == IDLE;
   assign valid_o  = state == DONE;
   assign tag_o    = tag_q;
   assign result_o = op_q[2] ? (op_q[1] ? rem : quo)
                             : ((op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
   assign zero_o   = result_o == '0;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors, random ops vs an arithmetic reference, and handshake corner cases.
module tb_muldiv_unit;
   localparam int XLEN = 32, TAG_W = 5;
   logic clk_i = 0, rst_n_i = 0, valid_i = 0, flush_i = 0, ready_i = 1;
   logic [2:0] op_i = '0;
   logic [XLEN-1:0] operand1_i = '0, operand2_i = '0;
   logic [TAG_W-1:0] tag_i = '0;
   logic ready_o, valid_o, zero_o;
   logic [XLEN-1:0] result_o;
   logic [TAG_W-1:0] tag_o;
   int errs = 0, n_chk = 0;

   muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
      .operand1_i(operand1_i), .operand2_i(operand2_i), .tag_i(tag_i), .flush_i(flush_i),
      .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .tag_o(tag_o), .zero_o(zero_o));

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
      longint sa = longint'($signed(a)), sb = longint'($signed(b));
      longint ua = longint'({32'b0, a}), ub = longint'({32'b0, b});
      int ia = int'(a), ib = int'(b);
      logic [63:0] p;
      logic ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         3'd0: begin p = 64'(sa * sb); return p[31:0]; end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = 64'(ua * ub); return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ov ? a : 32'(ia / ib);
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ov ? 32'h0 : 32'(ia % ib);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int lat_exp(logic [2:0] op, logic [31:0] a, logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      if (b == 0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
      return 33;
   endfunction

   // called at #1 after a rising edge with the unit idle
   task automatic run(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [TAG_W-1:0] tag,
                      output logic [31:0] res, output int lat);
      op_i = op; operand1_i = a; operand2_i = b; tag_i = tag; valid_i = 1;
      @(posedge clk_i); #1;
      valid_i = 0;
      lat = 1;
      while (!valid_o && lat < 100) begin
         @(posedge clk_i); #1;
         lat++;
      end
      res = result_o;
   endtask

   task automatic exec(string name, logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [TAG_W-1:0] tag);
      logic [31:0] res, exp;
      int lat;
      exp = ref_model(op, a, b);
      run(op, a, b, tag, res, lat);
      check({name, " result"}, res, exp);
      check({name, " latency"}, lat, lat_exp(op, a, b));
      check({name, " tag"}, tag_o, tag);
      check({name, " zero"}, zero_o, exp == 0);
      @(posedge clk_i); #1;
      check({name, " back to idle"}, {ready_o, valid_o}, 2'b10);
   endtask

   initial begin
      vec_t vt[$];
      logic [31:0] res, a, b;
      logic [2:0] op;
      int lat, seen;
      vt.push_back('{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB});
      vt.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
      vt.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF});
      vt.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
      vt.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD});
      vt.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF});
      vt.push_back('{3'd5, 32'd100, 32'd7, 32'd14});
      vt.push_back('{3'd7, 32'd100, 32'd7, 32'd2});
      vt.push_back('{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF});
      vt.push_back('{3'd6, 32'd5, 32'd0, 32'd5});
      vt.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
      vt.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
      vt.push_back('{3'd0, 32'd12345, 32'd0, 32'd0});

      repeat (2) @(posedge clk_i);
      #1;
      check("reset outputs", {ready_o, valid_o, result_o, tag_o, zero_o}, {2'b10, 32'h0, 5'h0, 1'b1});
      rst_n_i = 1;
      @(posedge clk_i); #1;

      foreach (vt[i]) begin
         logic [31:0] tv;
         tv = vt[i].exp;
         check($sformatf("table %0d model", i), ref_model(vt[i].op, vt[i].a, vt[i].b), tv);
         exec($sformatf("table %0d", i), vt[i].op, vt[i].a, vt[i].b, TAG_W'(i + 1));
      end

      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a = $urandom;
         case ($urandom_range(0, 9))
            0: b = 0;
            1: b = 32'hFFFF_FFFF;
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: b = $urandom;
         endcase
         exec($sformatf("rand %0d op%0d", i, op), op, a, b, TAG_W'($urandom));
      end

      // back-pressure: result held in DONE, a new request is ignored
      ready_i = 0;
      run(3'd5, 32'd100, 32'd7, 5'd9, res, lat);
      check("bp first result", res, 32'd14);
      op_i = 3'd0; operand1_i = 3; operand2_i = 3; tag_i = 5'd2; valid_i = 1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_i); #1;
         check($sformatf("bp hold %0d", i), {valid_o, ready_o, result_o, tag_o}, {2'b10, 32'd14, 5'd9});
      end
      valid_i = 0; ready_i = 1;
      @(posedge clk_i); #1;
      check("bp release", {ready_o, valid_o}, 2'b10);
      exec("bp follow-up", 3'd0, 32'd3, 32'd3, 5'd2);

      // flush during divide
      op_i = 3'd4; operand1_i = 32'd1000; operand2_i = 32'd3; tag_i = 5'd4; valid_i = 1;
      @(posedge clk_i); #1;
      valid_i = 0;
      repeat (9) @(posedge clk_i);
      #1 flush_i = 1;
      @(posedge clk_i); #1;
      flush_i = 0;
      check("flush idle", {ready_o, valid_o}, 2'b10);
      seen = 0;
      repeat (40) begin
         @(posedge clk_i); #1;
         if (valid_o) seen = 1;
      end
      check("flush no result", seen, 0);

      // flush beats a same-cycle request
      op_i = 3'd0; operand1_i = 32'd5; operand2_i = 32'd5; valid_i = 1; flush_i = 1;
      @(posedge clk_i); #1;
      valid_i = 0; flush_i = 0;
      check("flush priority", {ready_o, valid_o}, 2'b10);
      seen = 0;
      repeat (40) begin
         @(posedge clk_i); #1;
         if (valid_o) seen = 1;
      end
      check("flush priority no result", seen, 0);

      // asynchronous reset in the middle of a calculation
      op_i = 3'd0; operand1_i = 32'd7; operand2_i = 32'hFFFF_FFFD; tag_i = 5'd7; valid_i = 1;
      @(posedge clk_i); #1;
      valid_i = 0;
      repeat (5) @(posedge clk_i);
      #2 rst_n_i = 0;
      #1 check("async reset", {ready_o, valid_o, result_o, tag_o, zero_o}, {2'b10, 32'h0, 5'h0, 1'b1});
      @(negedge clk_i);
      rst_n_i = 1;
      @(posedge clk_i); #1;
      exec("after reset", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd11);

      $display("Result: errors=%0d of %0d checks", errs, n_chk);
      $finish;
   end
endmodule
